// File: rtl/bram_dp_ctl.sv
// True dual-port column-write RAM with request/valid handshake, selectable read latency,
// same-port read-during-write modes, port-A-wins write collision handling and post-reset clear.
module bram_dp_ctl #(
  parameter int NUM_COL        = 16,
  parameter int COL_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int RD_LATENCY     = 1,
  parameter int WR_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  output logic                           init_done,
  input  logic                           req_a,
  input  logic [NUM_COL-1:0]             wen_a,
  input  logic [ADDR_WIDTH-1:0]          addr_a,
  input  logic [NUM_COL*COL_WIDTH-1:0]   din_a,
  output logic [NUM_COL*COL_WIDTH-1:0]   dout_a,
  output logic                           dout_valid_a,
  input  logic                           req_b,
  input  logic [NUM_COL-1:0]             wen_b,
  input  logic [ADDR_WIDTH-1:0]          addr_b,
  input  logic [NUM_COL*COL_WIDTH-1:0]   din_b,
  output logic [NUM_COL*COL_WIDTH-1:0]   dout_b,
  output logic                           dout_valid_b,
  output logic                           collision
);
  localparam int W     = NUM_COL * COL_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [W-1:0] mem [DEPTH];

  logic [1:0]          state_reg, state_next;
  logic [ADDR_WIDTH:0] clr_cnt_reg, clr_cnt_next;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        clr_cnt_next = '0;
        state_next   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == CLR_LAST) state_next = ST_READY;
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  assign init_done = (state_reg == ST_READY);

  logic                  acc_a, acc_b, same_addr, clr_we;
  logic [NUM_COL-1:0]    wen_b_win;
  logic [ADDR_WIDTH-1:0] clr_addr;

  assign acc_a     = req_a & init_done;
  assign acc_b     = req_b & init_done;
  assign same_addr = (addr_a == addr_b);
  assign clr_we    = (state_reg == ST_CLEAR);
  assign clr_addr  = clr_cnt_reg[ADDR_WIDTH-1:0];
  // Port B loses every column that port A also writes at the same address.
  assign wen_b_win = wen_b & ~(wen_a & {NUM_COL{acc_a & same_addr}});

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NUM_COL; i++) begin
        if (acc_a && wen_a[i])
          mem[addr_a][i*COL_WIDTH +: COL_WIDTH] <= din_a[i*COL_WIDTH +: COL_WIDTH];
        if (acc_b && wen_b_win[i])
          mem[addr_b][i*COL_WIDTH +: COL_WIDTH] <= din_b[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  logic [W-1:0] old_a, old_b, rd_a_next, rd_b_next, rd_a_reg, rd_b_reg;
  logic         rd_valid_a_reg, rd_valid_b_reg, collision_reg;

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      // Written columns return din, old data, or the held output depending on WR_MODE.
      assign rd_a_next[gi*COL_WIDTH +: COL_WIDTH] =
        !wen_a[gi]    ? old_a[gi*COL_WIDTH +: COL_WIDTH] :
        (WR_MODE == 0) ? din_a[gi*COL_WIDTH +: COL_WIDTH] :
        (WR_MODE == 1) ? old_a[gi*COL_WIDTH +: COL_WIDTH] :
                         rd_a_reg[gi*COL_WIDTH +: COL_WIDTH];
      assign rd_b_next[gi*COL_WIDTH +: COL_WIDTH] =
        !wen_b[gi]    ? old_b[gi*COL_WIDTH +: COL_WIDTH] :
        (WR_MODE == 0) ? din_b[gi*COL_WIDTH +: COL_WIDTH] :
        (WR_MODE == 1) ? old_b[gi*COL_WIDTH +: COL_WIDTH] :
                         rd_b_reg[gi*COL_WIDTH +: COL_WIDTH];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_reg       <= '0;
      rd_b_reg       <= '0;
      rd_valid_a_reg <= 1'b0;
      rd_valid_b_reg <= 1'b0;
      collision_reg  <= 1'b0;
    end else begin
      rd_valid_a_reg <= acc_a;
      rd_valid_b_reg <= acc_b;
      if (acc_a) rd_a_reg <= rd_a_next;
      if (acc_b) rd_b_reg <= rd_b_next;
      collision_reg  <= acc_a & acc_b & same_addr & (|(wen_a & wen_b));
    end
  end

  assign collision = collision_reg;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [W-1:0] dout_a_reg, dout_b_reg;
      logic         valid_a_reg, valid_b_reg;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          dout_a_reg  <= '0;
          dout_b_reg  <= '0;
          valid_a_reg <= 1'b0;
          valid_b_reg <= 1'b0;
        end else begin
          dout_a_reg  <= rd_a_reg;
          dout_b_reg  <= rd_b_reg;
          valid_a_reg <= rd_valid_a_reg;
          valid_b_reg <= rd_valid_b_reg;
        end
      end
      assign dout_a       = dout_a_reg;
      assign dout_b       = dout_b_reg;
      assign dout_valid_a = valid_a_reg;
      assign dout_valid_b = valid_b_reg;
    end else begin : g_lat1
      assign dout_a       = rd_a_reg;
      assign dout_b       = rd_b_reg;
      assign dout_valid_a = rd_valid_a_reg;
      assign dout_valid_b = rd_valid_b_reg;
    end
  endgenerate

endmodule

// File: doc/bram_dp_ctl.md
Name: bram_dp_ctl

Overview:
Parametrised true dual-port column-write block RAM with a controller wrapped around it, for the host-side buffers. Adds a per-port request/valid handshake and a selectable read latency of 1 or 2. Adds a selectable same-port read-during-write mode, deterministic cross-port collision resolution with a collision flag, and an optional post-reset memory clear sequencer. Both ports run on one clock.

Parameters:
NUM_COL, 16, number of independently write-enabled columns per word
COL_WIDTH, 32, bits per column; word width W = NUM_COL*COL_WIDTH
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH
RD_LATENCY, 1, cycles from accepted request to dout_valid; legal values 1 or 2 (2 adds an output register)
WR_MODE, 0, same-port read-during-write: 0 write-first, 1 read-first, 2 no-change
CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = no clear

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
init_done  out  1  high once the block accepts requests
req_a  in  1  port A access request
wen_a  in  NUM_COL  port A column write enables, sampled with req_a
addr_a  in  ADDR_WIDTH  port A address
din_a  in  W  port A write data
dout_a  out  W  port A read data
dout_valid_a  out  1  port A read data valid
req_b, wen_b, addr_b, din_b, dout_b, dout_valid_b  same as port A, for port B
collision  out  1  one-cycle pulse on a cross-port write/write overlap

Behaviour:
- Reset (reset_n low, async): init_done=0, dout_a=dout_b=0, dout_valid_a=dout_valid_b=0, collision=0, FSM=IDLE, clear counter=0. Reset does not alter array contents.
- FSM states: IDLE, CLEAR, READY.
  - IDLE goes to CLEAR on the first clock after reset release if CLEAR_ON_RESET=1; otherwise it goes to READY.
  - CLEAR writes all-zero words to address 0, 1, ..., DEPTH-1, one address per cycle.
  - CLEAR goes to READY in the cycle after address DEPTH-1 is written. The clear counter is ADDR_WIDTH+1 bits so the terminal count does not wrap.
  - init_done=1 only in READY. READY is held until reset.
- Clear timing: DEPTH+1 cycles from reset release to init_done high with CLEAR_ON_RESET=1; 1 cycle with CLEAR_ON_RESET=0.
- Reset asserted mid-CLEAR aborts the sequence. After release, clearing restarts at address 0.
- While init_done=0, req_a and req_b are ignored: no array write and no dout_valid pulse.
- Request acceptance: an access is accepted when req_x=1 and init_done=1.
- Every accepted access produces a read, whether or not any wen bit is set.
- Reads: dout_x and dout_valid_x update RD_LATENCY cycles after the accepted edge. dout_valid_x is high for exactly one cycle per accepted request. Back-to-back requests on consecutive cycles are supported, giving one result per cycle.
- dout_x holds its last value when no read completes. dout_valid_x=0 in those cycles.
- Writes: column i is written on the accept edge when wen_x[i]=1.
- Same-port read-during-write (per column with wen_x[i]=1):
  - WR_MODE 0: returned data is din_x.
  - WR_MODE 1: returned data is the old array value.
  - WR_MODE 2: the dout_x column holds its previous value. dout_valid_x still pulses.
  - Columns with wen_x[i]=0 always return the array value.
- Cross-port read vs write: accepted on both ports, same address, only one port writing. The reading port returns the old array contents for the written columns.
- Cross-port write/write: accepted on both ports, addr_a==addr_b, and (wen_a & wen_b) nonzero.
  - Port A wins on every overlapping column.
  - Port B writes only its non-overlapping columns.
  - collision=1 for one cycle, the cycle after the accept edge.
  - Each port's own read data still follows its WR_MODE, using its own din.
- Different addresses on the two ports never interact.
- RD_LATENCY=2: the second stage is a plain register on data and valid, and resets to 0.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=32: release reset -> init_done rises on cycle 33. Read all 32 addresses -> every dout_a=0, one dout_valid_a pulse per read. A req_a asserted before init_done -> no valid pulse.
- WR_MODE=0, RD_LATENCY=1: A writes addr 3, wen all-ones, din=0xA5.. -> dout_a=din on the next cycle. Then WR_MODE=1 -> old data returned. Then WR_MODE=2 -> dout_a unchanged and dout_valid_a=1.
- Partial columns: wen_a=0x0001, din col0=0x11111111, addr 5 previously 0 -> a later read of addr 5 gives col0=0x11111111 and other columns 0.
- Collision: same cycle, addr 7, wen_a=0x00FF din all 0xAA; wen_b=0x0FF0 din all 0xBB -> collision pulses once. A read of addr 7 gives columns 0-7 0xAA, columns 8-11 0xBB, columns 12-15 unchanged.
- RD_LATENCY=2: 4 back-to-back reads on port B at addrs 0-3 -> 4 consecutive dout_valid_b pulses starting 2 cycles after the first request, in order. Port A idle throughout.
- Reset mid-clear: assert reset_n=0 at clear address 10 for 2 cycles, then release -> init_done low, then high DEPTH+1 cycles after release. All words read back 0.
